spi_cmd_bridge: RTL and testbench
=================================

# spi_cmd_bridge

Command-layer stage directly downstream of `spi_slave`. It consumes each received byte (`in_byte`/`finished`) and supplies the next byte to shift out (`out_byte`). Decodes a framed command/address/data protocol from the cartridge programmer and turns it into single-byte read/write transactions on the cart memory port. It runs in the system clock domain and synchronizes all SPI-side strobes internally.

## Interface
- `ADDR_W`, 24: memory address width (SNES 16 MB space)
- `SYNC_STAGES`, 2: flip-flop depth of the `cs`/`finished` synchronizers (≥2)
- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `cs` in 1: SPI chip select from the pin, active low, asynchronous to `clk`
- `finished` in 1: `spi_slave` byte-done level, high ≥2 `clk` periods per byte, asynchronous
- `in_byte` in 8: byte received by `spi_slave`, stable while `finished` is high
- `out_byte` out 8: byte `spi_slave` shifts out on the next byte
- `mem_req` out 1: memory request, held until `mem_ack`
- `mem_we` out 1: 1 = write, 0 = read; valid with `mem_req`
- `mem_addr` out ADDR_W: transaction address
- `mem_wdata` out 8: write data
- `mem_ack` in 1: one-cycle completion strobe
- `mem_rdata` in 8: read data, valid with `mem_ack`
- `busy` out 1: high whenever a frame is active (`cs` low after synchronization)
- `err` out 1: sticky error for the current frame

## Operation
- Frame = synchronized `cs` low period. Byte event = rising edge of synchronized `finished`.
- Commands are sent in the first byte of a frame: 0x02 WRITE, 0x03 READ, 0x9F ID. Any other value → IGNORE, `err`=1.
- States: IDLE → CMD on `cs` fall. CMD → ADDR2 (WRITE/READ) or ID. ADDR2 → ADDR1 → ADDR0: the address is MSB first, with bits above ADDR_W discarded. ADDR0 → DATA. DATA and IGNORE remain until `cs` rises.
- ID: `out_byte` = 0xA5 for all remaining bytes.
- WRITE/DATA: each byte event issues `mem_req`, `mem_we`=1, `mem_addr`=addr, `mem_wdata`=`in_byte`. On `mem_ack` the address increments, modulo 2^ADDR_W.
- READ: the ADDR0 byte event issues a prefetch read at addr. On `mem_ack`, `out_byte`←`mem_rdata` and the address increments. Each DATA byte event issues the next prefetch.
- Byte event while `mem_req` is still pending → the byte is dropped, `err`=1, and the outstanding request completes normally.
- `cs` rise at any point → return to IDLE. A pending `mem_req` is held until `mem_ack`; no new requests are issued. `err` clears on the next `cs` fall.
- Outside READ/ID data phases, `out_byte` = 0x00.

## Timing
- Reset values: `out_byte`=0x00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0x00, `busy`=0, `err`=0, state=IDLE.
- Byte event latency: `finished` pin rise → internal event after SYNC_STAGES+1 `clk` cycles. `mem_req` asserts on the following cycle.
- `mem_req` drops in the cycle after `mem_ack` is sampled. At most one request is outstanding.
- For reads, `out_byte` updates on the cycle after `mem_ack`. The bench master must leave ≥ (SYNC_STAGES+3+memory latency) `clk` cycles between byte events.
- Simultaneous `cs` rise and byte event: the `cs` rise wins and the byte is discarded.

## Configuration
- `SPI_CMD_BRIDGE_AUTOINC_EN` defined: the address increments after every data transfer, as described above.
- Not defined: the address stays fixed for the whole frame. Repeated reads return the same location and repeated writes overwrite it.

## Structure
- The shared package `spi_cmd_pkg` holds the command opcodes (0x02, 0x03, 0x9F), the ID byte 0xA5, and the state enumeration.
- One sub-module, `sync_edge`, is instantiated for `cs` and `finished`. It is a SYNC_STAGES flop chain with rise/fall pulse outputs and resets to the inactive level (`cs`=1, `finished`=0).

## Test plan
- WRITE frame 0x02,0x00,0x12,0x34,0xAA,0xBB → two requests: we=1 at 0x001234/0xAA, then 0x001235/0xBB. `err`=0.
- READ frame 0x03,0x00,0x80,0x00 + 2 dummies, memory returns 0x11 then 0x22 → `out_byte` is 0x11 during the first dummy and 0x22 during the second. Read addresses are 0x008000, 0x008001, 0x008002.
- WRITE at 0xFFFFFF with 2 data bytes → second write goes to 0x000000 (wrap). With the macro undefined, both writes go to 0xFFFFFF.
- Opcode 0x55 followed by 3 bytes → no `mem_req`, `err`=1. The next frame's `cs` fall clears `err`.
- `mem_ack` delayed past the next byte event → that byte is dropped and `err`=1. `cs` raised mid-request → `mem_req` holds until ack, then the block returns to IDLE.
- `rst_n` pulsed low mid-READ → all outputs take their reset values immediately. The next frame decodes correctly.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared opcodes, ID byte and state encoding for the SPI command bridge.
package spi_cmd_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_ID    = 8'h9F;
   localparam logic [7:0] ID_BYTE   = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR2,
      ST_ADDR1,
      ST_ADDR0,
      ST_DATA,
      ST_ID,
      ST_IGNORE
   } state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses on the synchronized level.
module sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{RST_VAL}};
         q_d   <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         q_d   <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~q_d;
   assign fall = ~q & q_d;

endmodule

// File: rtl/spi_cmd_bridge.sv
// Framed SPI command decoder driving single-byte cart memory transactions.
// Address auto-increment is enabled by defining SPI_CMD_BRIDGE_AUTOINC_EN.
module spi_cmd_bridge
   import spi_cmd_pkg::*;
#(
   parameter int ADDR_W      = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cs,
   input  logic              finished,
   input  logic [7:0]        in_byte,
   output logic [7:0]        out_byte,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              err
);

   logic cs_s, cs_rise, cs_fall;
   logic fin_rise, fin_unused_q, fin_unused_fall;

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (cs),
      .q    (cs_s),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_fin_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (finished),
      .q    (fin_unused_q),
      .rise (fin_rise),
      .fall (fin_unused_fall)
   );

   // cs synchronizer output is a flop, so busy is glitch-free
   assign busy = ~cs_s;

   state_t            state;
   logic              is_read;
   logic              req_own;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_next;

   // MSB-first shift; bits above ADDR_W fall off the top
   assign addr_next = {addr[ADDR_W-9:0], in_byte};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         is_read   <= 1'b0;
         req_own   <= 1'b0;
         addr      <= '0;
         out_byte  <= 8'h00;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
         err       <= 1'b0;
      end else begin
         // Completion; only requests issued by the live frame touch addr/out_byte
         if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            req_own <= 1'b0;
            if (req_own && state == ST_DATA) begin
               if (!mem_we)
                  out_byte <= mem_rdata;
`ifdef SPI_CMD_BRIDGE_AUTOINC_EN
               addr <= addr + ADDR_W'(1);
`endif
            end
         end

         if (cs_rise) begin
            state    <= ST_IDLE;
            out_byte <= 8'h00;
            req_own  <= 1'b0;
         end else if (cs_fall) begin
            state    <= ST_CMD;
            err      <= 1'b0;
            addr     <= '0;
            out_byte <= 8'h00;
         end else if (fin_rise) begin
            case (state)
               ST_CMD: begin
                  if (in_byte == CMD_WRITE) begin
                     is_read <= 1'b0;
                     state   <= ST_ADDR2;
                  end else if (in_byte == CMD_READ) begin
                     is_read <= 1'b1;
                     state   <= ST_ADDR2;
                  end else if (in_byte == CMD_ID) begin
                     out_byte <= ID_BYTE;
                     state    <= ST_ID;
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IGNORE;
                  end
               end
               ST_ADDR2: begin
                  addr  <= addr_next;
                  state <= ST_ADDR1;
               end
               ST_ADDR1: begin
                  addr  <= addr_next;
                  state <= ST_ADDR0;
               end
               ST_ADDR0: begin
                  addr  <= addr_next;
                  state <= ST_DATA;
                  if (is_read) begin
                     if (mem_req) begin
                        err <= 1'b1;
                     end else begin
                        mem_req  <= 1'b1;
                        req_own  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= addr_next;
                     end
                  end
               end
               ST_DATA: begin
                  // One outstanding request max: an overlapping byte is lost
                  if (mem_req) begin
                     err <= 1'b1;
                  end else begin
                     mem_req  <= 1'b1;
                     req_own  <= 1'b1;
                     mem_we   <= ~is_read;
                     mem_addr <= addr;
                     if (!is_read)
                        mem_wdata <= in_byte;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_cmd_bridge.sv
// Self-checking bench for spi_cmd_bridge: vector table plus corner sequences.
`timescale 1ns/1ps
module tb_spi_cmd_bridge;

`ifdef SPI_CMD_BRIDGE_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs;
   logic        finished;
   logic [7:0]  in_byte;
   logic [7:0]  out_byte;
   logic        mem_req;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        busy;
   logic        err;

   spi_cmd_bridge #(.ADDR_W(24), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs       (cs),
      .finished (finished),
      .in_byte  (in_byte),
      .out_byte (out_byte),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [23:0] addr;
      logic [7:0]  wdata;
   } txn_t;

   typedef struct {
      logic [7:0]  op;
      logic [23:0] addr;
      logic [7:0]  data;
      logic [7:0]  rdata;
      logic        exp_err;
      logic [7:0]  exp_out;
   } vec_t;

   txn_t       exp_q[$];
   logic [7:0] rd_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   bit         hold_ack = 1'b0;
   int         ack_lat  = 2;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Memory model: acks after ack_lat cycles and scores each request against the queue
   initial begin
      int wait_cnt;
      txn_t t;
      wait_cnt  = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (mem_req && !hold_ack) begin
            if (wait_cnt >= ack_lat) begin
               wait_cnt = 0;
               if (exp_q.size() == 0) begin
                  check("spurious_req", 32'(exp_q.size()), 32'd1);
                  mem_rdata = 8'h00;
               end else begin
                  t = exp_q.pop_front();
                  check("req_we", {31'b0, mem_we}, {31'b0, t.we});
                  check("req_addr", {8'b0, mem_addr}, {8'b0, t.addr});
                  if (t.we)
                     check("req_wdata", {24'b0, mem_wdata}, {24'b0, t.wdata});
                  else
                     mem_rdata = (rd_q.size() != 0) ? rd_q.pop_front() : 8'h00;
               end
               mem_ack = 1'b1;
            end else begin
               wait_cnt++;
            end
         end else if (!mem_req) begin
            wait_cnt = 0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      in_byte  = b;
      finished = 1'b1;
      repeat (4) @(negedge clk);
      finished = 1'b0;
      repeat (14) @(negedge clk);
   endtask

   task automatic frame_start();
      cs = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic frame_end();
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || mem_req) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", 32'(exp_q.size()) + {31'b0, mem_req}, 32'd0);
   endtask

   task automatic push_wr(input logic [23:0] a, input logic [7:0] d);
      txn_t t;
      t.we = 1'b1; t.addr = a; t.wdata = d;
      exp_q.push_back(t);
   endtask

   task automatic push_rd(input logic [23:0] a, input logic [7:0] rd);
      txn_t t;
      t.we = 1'b0; t.addr = a; t.wdata = 8'h00;
      exp_q.push_back(t);
      rd_q.push_back(rd);
   endtask

   task automatic send_addr(input logic [23:0] a);
      send_byte(a[23:16]);
      send_byte(a[15:8]);
      send_byte(a[7:0]);
   endtask

   function automatic logic [23:0] nxt(input logic [23:0] a);
      return AUTOINC ? a + 24'd1 : a;
   endfunction

   initial begin
      vec_t vecs[5];
      vec_t v;
      logic [23:0] a;

      vecs[0] = '{8'h02, 24'h001234, 8'hAA, 8'h00, 1'b0, 8'h00};
      vecs[1] = '{8'h02, 24'hABCDEF, 8'h5C, 8'h00, 1'b0, 8'h00};
      vecs[2] = '{8'h9F, 24'h000000, 8'h00, 8'h00, 1'b0, 8'hA5};
      vecs[3] = '{8'h55, 24'h123456, 8'h00, 8'h00, 1'b1, 8'h00};
      vecs[4] = '{8'h03, 24'h000010, 8'h00, 8'h77, 1'b0, 8'h77};

      rst_n    = 1'b0;
      cs       = 1'b1;
      finished = 1'b0;
      in_byte  = 8'h00;
      repeat (5) @(negedge clk);
      check("rst_out_byte", {24'b0, out_byte}, 32'h00);
      check("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check("rst_mem_addr", {8'b0, mem_addr}, 32'd0);
      check("rst_mem_wdata", {24'b0, mem_wdata}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_err", {31'b0, err}, 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Table of single-transfer frames
      for (int i = 0; i < 5; i++) begin
         v = vecs[i];
         frame_start();
         check("vec_busy", {31'b0, busy}, 32'd1);
         send_byte(v.op);
         send_byte(v.addr[23:16]);
         send_byte(v.addr[15:8]);
         if (v.op == 8'h03) push_rd(v.addr, v.rdata);
         send_byte(v.addr[7:0]);
         if (v.op == 8'h02) begin
            push_wr(v.addr, v.data);
            send_byte(v.data);
         end
         check("vec_out_byte", {24'b0, out_byte}, {24'b0, v.exp_out});
         check("vec_err", {31'b0, err}, {31'b0, v.exp_err});
         frame_end();
         drain();
         check("vec_out_idle", {24'b0, out_byte}, 32'h00);
      end

      // Two-byte write
      frame_start();
      send_byte(8'h02);
      send_addr(24'h001234);
      push_wr(24'h001234, 8'hAA);
      send_byte(8'hAA);
      push_wr(nxt(24'h001234), 8'hBB);
      send_byte(8'hBB);
      check("wr2_err", {31'b0, err}, 32'd0);
      frame_end();
      drain();

      // Read with prefetch and two dummy bytes
      frame_start();
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h80);
      push_rd(24'h008000, 8'h11);
      send_byte(8'h00);
      check("rd_dummy1_out", {24'b0, out_byte}, 32'h11);
      push_rd(nxt(24'h008000), 8'h22);
      send_byte(8'h00);
      check("rd_dummy2_out", {24'b0, out_byte}, 32'h22);
      push_rd(nxt(nxt(24'h008000)), 8'h33);
      send_byte(8'h00);
      check("rd_dummy3_out", {24'b0, out_byte}, 32'h33);
      check("rd_err", {31'b0, err}, 32'd0);
      frame_end();
      drain();
      check("rd_out_after_cs", {24'b0, out_byte}, 32'h00);

      // Address wrap at top of space
      frame_start();
      send_byte(8'h02);
      send_addr(24'hFFFFFF);
      push_wr(24'hFFFFFF, 8'h01);
      send_byte(8'h01);
      push_wr(nxt(24'hFFFFFF), 8'h02);
      send_byte(8'h02);
      frame_end();
      drain();

      // Unknown opcode sets err; the next frame clears it
      frame_start();
      send_byte(8'h55);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      check("bad_op_err", {31'b0, err}, 32'd1);
      check("bad_op_req", {31'b0, mem_req}, 32'd0);
      frame_end();
      check("bad_op_err_sticky", {31'b0, err}, 32'd1);
      frame_start();
      check("bad_op_err_clr", {31'b0, err}, 32'd0);
      frame_end();

      // Late ack: overlapping byte is dropped
      frame_start();
      send_byte(8'h02);
      send_addr(24'h000100);
      hold_ack = 1'b1;
      push_wr(24'h000100, 8'hC1);
      send_byte(8'hC1);
      send_byte(8'hC2);
      check("late_ack_err", {31'b0, err}, 32'd1);
      check("late_ack_req_held", {31'b0, mem_req}, 32'd1);
      check("late_ack_wdata", {24'b0, mem_wdata}, 32'hC1);
      hold_ack = 1'b0;
      drain();
      push_wr(nxt(24'h000100), 8'hC3);
      send_byte(8'hC3);
      drain();
      frame_end();

      // cs rises while a request is outstanding
      frame_start();
      send_byte(8'h02);
      send_addr(24'h000200);
      hold_ack = 1'b1;
      push_wr(24'h000200, 8'hD1);
      send_byte(8'hD1);
      cs = 1'b1;
      repeat (10) @(negedge clk);
      check("cs_mid_req_held", {31'b0, mem_req}, 32'd1);
      check("cs_mid_busy", {31'b0, busy}, 32'd0);
      send_byte(8'hEE);
      hold_ack = 1'b0;
      drain();
      repeat (3) @(negedge clk);
      check("cs_mid_req_done", {31'b0, mem_req}, 32'd0);

      // Reset in the middle of a read
      frame_start();
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h40);
      push_rd(24'h004000, 8'h99);
      send_byte(8'h00);
      check("rstmid_out_pre", {24'b0, out_byte}, 32'h99);
      hold_ack = 1'b1;
      push_rd(nxt(24'h004000), 8'h98);
      send_byte(8'h00);
      rst_n = 1'b0;
      #1;
      check("rstmid_out_byte", {24'b0, out_byte}, 32'h00);
      check("rstmid_mem_req", {31'b0, mem_req}, 32'd0);
      check("rstmid_mem_we", {31'b0, mem_we}, 32'd0);
      check("rstmid_mem_addr", {8'b0, mem_addr}, 32'd0);
      check("rstmid_mem_wdata", {24'b0, mem_wdata}, 32'd0);
      check("rstmid_busy", {31'b0, busy}, 32'd0);
      check("rstmid_err", {31'b0, err}, 32'd0);
      exp_q.delete();
      rd_q.delete();
      hold_ack = 1'b0;
      cs = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      a = 24'h000055;
      frame_start();
      send_byte(8'h02);
      send_addr(a);
      push_wr(a, 8'h66);
      send_byte(8'h66);
      check("post_rst_err", {31'b0, err}, 32'd0);
      frame_end();
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
      $fatal(1, "watchdog");
   end

endmodule
